fp_unit_arbiter: RTL
====================

# fp_unit_arbiter

Round-robin arbiter that shares one fixed-latency, fully pipelined floating-point unit among `NUM_REQ` requesters. The unit has a go/done trigger pair and an operand/result pair, for example the 32-bit float-to-int converter. The arbiter accepts at most one operation per cycle and issues it to the unit. It tracks the owner of every in-flight operation in a tag pipeline aligned to the unit latency, and steers each result back to its requester. It sits between the per-lane request logic and the shared unit instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: operand and result width.
- `LATENCY`, default 6: unit go-to-done latency in cycles, at least 1. It must equal the instantiated unit's latency.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_data`  in  `NUM_REQ*WIDTH`  operands; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready`  out  `NUM_REQ`  one-hot grant (combinational); the request is accepted when `req_valid[i]` and `req_ready[i]` are both high.
- `unit_go`  out  1  registered go trigger to the unit.
- `unit_operand`  out  `WIDTH`  registered operand to the unit.
- `unit_done`  in  1  done trigger from the unit.
- `unit_result`  in  `WIDTH`  result from the unit, valid while `unit_done` is high.
- `resp_valid`  out  `NUM_REQ`  one-hot, single-cycle result strobe.
- `resp_data`  out  `WIDTH`  registered result. It is valid only while some `resp_valid` bit is high.
- `busy`  out  1  high while any operation is issued but not yet responded.
- `err`  out  1  sticky protocol error: a tag reached the head of the tag pipeline with `unit_done` low.

## Operation
- Arbitration:
  - Search starts at `(last+1) mod NUM_REQ` and covers all requesters. `last` is the most recently granted index; its reset value is `NUM_REQ-1`, so index 0 has priority first.
  - At most one `req_ready` bit is high, and only for a requester with `req_valid` high.
  - `req_ready` is all-zero when no request is valid.
  - `last` updates only on a grant.
- Issue:
  - On an accept from requester g, the next edge loads `unit_go`=1, `unit_operand`=`req_data[g]` and `issue_id`=g.
  - With no accept, `unit_go` is 0 and `unit_operand` holds its value.
- Tag pipeline:
  - `LATENCY` entries, each {valid, id}.
  - Each edge the top entry loads {`unit_go`, `issue_id`} and every other entry shifts one place toward the head.
  - The head entry is therefore time-aligned with `unit_done` for the same operation.
- Response:
  - If the head entry is valid and `unit_done` is high, the next edge sets `resp_valid` to one-hot(head.id) and loads `resp_data` from `unit_result`.
  - Otherwise the next edge clears `resp_valid` to 0 and `resp_data` holds its value.
  - There is no response backpressure; requesters must take the strobe.
- Mismatches:
  - Head valid with `unit_done` low: `err` sets and stays set until reset. No response is produced.
  - `unit_done` high with head invalid: ignored silently, no `err`. This is legal because the unit's trigger pipeline is not reset and may emit stale done pulses after reset.
- `busy` is the OR of `unit_go`, every tag valid bit, and any `resp_valid` bit.
- Reset (asynchronous, any time):
  - `unit_go`=0, `unit_operand`=0, `issue_id`=0.
  - All tag valid bits and ids = 0.
  - `resp_valid`=0, `resp_data`=0, `err`=0, `last`=`NUM_REQ-1`.
  - In-flight operations are discarded, and their later done pulses are ignored under the mismatch rule above.

## Timing
- Accept in cycle T:
  - `unit_go` is high in T+1.
  - `unit_done` is expected in T+1+`LATENCY`.
  - `resp_valid` is high in T+2+`LATENCY`, which is T+8 at the defaults.
- Throughput is one accept per cycle with no bubbles. Responses return in accept order.
- `req_ready` depends combinationally on `req_valid` and `last` only, never on `req_data`.
- `busy` falls in the cycle after the last `resp_valid` strobe.

## Test plan
- Single op: requester 2 sends 0x40490FDB in cycle 0. Expect `unit_go` in cycle 1, then the unit returns 3 → `resp_valid`=0b0100 and `resp_data`=3 in cycle 8. `busy` is high in cycles 1-8 and low in cycle 9.
- Streaming: requester 0 holds `req_valid` for 10 cycles. Expect 10 accepts, 10 consecutive `unit_go` pulses and 10 consecutive responses to requester 0, in order, starting in cycle 8.
- Fairness: all four requesters hold `req_valid` → grants go 0,1,2,3,0,1 on consecutive cycles. Then, with `last`=2 and only requesters 1 and 3 valid, the next grant goes to 3.
- Mixed owners: accept ids 1,3,0 in cycles 0-2 → `resp_valid` = 0b0010, 0b1000, 0b0001 in cycles 8-10, each with the matching result.
- Reset mid-flight: issue three ops, then assert `reset` in cycle 4 while the unit still pulses done in cycles 7-9. Expect no `resp_valid`, `err`=0, and `busy`=0 from reset onward.
- Missing done: the unit model drops one done pulse → `err` rises the cycle after the expected done and stays high. The remaining responses are unaffected.

Source files
------------

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one fixed-latency pipelined FP unit.
// A tag pipeline aligned to the unit latency steers each result to its owner.
module fp_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     unit_go,
  output logic [WIDTH-1:0]         unit_operand,
  input  logic                     unit_done,
  input  logic [WIDTH-1:0]         unit_result,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     busy,
  output logic                     err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]     r_last;
  logic [IDW-1:0]     r_issue_id;
  logic               r_go;
  logic [WIDTH-1:0]   r_operand;
  logic [LATENCY-1:0] r_tag_v;
  logic [IDW-1:0]     r_tag_id [LATENCY];
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [WIDTH-1:0]   r_resp_data;
  logic               r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gid;
  logic               w_accept;
  logic [WIDTH-1:0]   w_gdata;
  logic [NUM_REQ-1:0] w_head_oh;
  logic               w_head_hit;
  logic               w_head_miss;

  // Round-robin search starting just after the last granted index
  always_comb begin
    w_grant  = '0;
    w_gid    = '0;
    w_accept = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_accept &&
          req_valid[(int'(r_last) + k) % NUM_REQ]) begin
        w_accept = 1'b1;
        w_gid    = IDW'((int'(r_last) + k) % NUM_REQ);
        w_grant[(int'(r_last) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_gdata   = req_data[int'(w_gid)*WIDTH +: WIDTH];

  // Remember the most recent grant; only moves when something is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= LAST_RST;
    end else if (w_accept) begin
      r_last <= w_gid;
    end
  end

  // Issue register: one go pulse per accept, operand held otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_go       <= 1'b0;
      r_operand  <= '0;
      r_issue_id <= '0;
    end else begin
      r_go <= w_accept;
      if (w_accept) begin
        r_operand  <= w_gdata;
        r_issue_id <= w_gid;
      end
    end
  end

  // Owner tags shift toward the head in step with the unit pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_id[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        r_tag_v[i]  <= r_tag_v[i+1];
        r_tag_id[i] <= r_tag_id[i+1];
      end
      r_tag_v[LATENCY-1]  <= r_go;
      r_tag_id[LATENCY-1] <= r_issue_id;
    end
  end

  assign w_head_oh   = NUM_REQ'(1) << r_tag_id[0];
  assign w_head_hit  = r_tag_v[0] && unit_done;
  assign w_head_miss = r_tag_v[0] && !unit_done;

  // Steer a matched result back to its owner as a one-cycle strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else if (w_head_hit) begin
      r_resp_valid <= w_head_oh;
      r_resp_data  <= unit_result;
    end else begin
      r_resp_valid <= '0;
    end
  end

  // Sticky flag for an expected done that never arrived
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_head_miss) begin
      r_err <= 1'b1;
    end
  end

  assign unit_go      = r_go;
  assign unit_operand = r_operand;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign err          = r_err;
  assign busy         = r_go | (|r_tag_v) | (|r_resp_valid);

endmodule
